// File: rtl/id_ctrl_pkg.sv
// Shared encodings and the registered control word for the ID/EX control stage.
package id_ctrl_pkg;

    localparam logic [3:0] ALU_ADDU = 4'h0;
    localparam logic [3:0] ALU_SUBU = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_J    = 2'd1;
    localparam logic [1:0] JMP_JR   = 2'd2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       ext_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] branch;
        logic [1:0] jump;
        logic [4:0] dest_reg;
    } ctrl_word_t;

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_main_decoder.sv
// Combinational MIPS main decoder: instruction word to control word plus illegal flag.
module main_decoder
    import id_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl,
    output logic        illegal
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign funct       = instr[5:0];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign unused_bits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RD_RD;
                ctrl.dest_reg  = rd;
                case (funct)
                    FN_ADDU: ctrl.alu_op = ALU_ADDU;
                    FN_SUBU: ctrl.alu_op = ALU_SUBU;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_SLL:  ctrl.alu_op = ALU_SLL;
                    FN_SRL:  ctrl.alu_op = ALU_SRL;
                    FN_SRA:  ctrl.alu_op = ALU_SRA;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.reg_dst   = RD_RT;
                        ctrl.dest_reg  = 5'd0;
                        ctrl.jump      = JMP_JR;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.dest_reg  = rt;
                // Logical immediates zero-extend; arithmetic/compare ones sign-extend.
                ctrl.ext_op    = (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU);
                case (op)
                    OP_SLTI:  ctrl.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl.alu_op = ALU_SLTU;
                    OP_ANDI:  ctrl.alu_op = ALU_AND;
                    OP_ORI:   ctrl.alu_op = ALU_OR;
                    OP_XORI:  ctrl.alu_op = ALU_XOR;
                    OP_LUI:   ctrl.alu_op = ALU_LUI;
                    default:  ctrl.alu_op = ALU_ADDU;
                endcase
            end
            OP_LW: begin
                ctrl.alu_op    = ALU_ADDU;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.dest_reg  = rt;
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADDU;
                ctrl.alu_src   = 1'b1;
                ctrl.ext_op    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUBU;
                ctrl.ext_op = 1'b1;
                ctrl.branch = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            OP_J: ctrl.jump = JMP_J;
            OP_JAL: begin
                ctrl.jump      = JMP_J;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = RD_RA;
                ctrl.dest_reg  = 5'd31;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) ctrl = '0;
    end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control register: decodes IF/ID instruction, handshakes both sides,
// inserts one bubble on a load-use hazard and counts those bubbles.
module id_ex_ctrl_stage
    import id_ctrl_pkg::*;
#(
    parameter int PERF_W          = 16,
    parameter bit ZERO_REG_HAZARD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    input  logic              flush,
    output logic [3:0]        Alu_op,
    output logic              Alu_src,
    output logic              Ext_op,
    output logic              Reg_write,
    output logic [1:0]        Reg_dst,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic [1:0]        Branch,
    output logic [1:0]        Jump,
    output logic [4:0]        Dest_reg,
    output logic              Illegal,
    output logic [PERF_W-1:0] bubble_cnt
);

    ctrl_word_t        dec_ctrl;
    ctrl_word_t        ctrl_q;
    logic              dec_illegal;
    logic              illegal_q;
    logic              valid_q;
    logic [PERF_W-1:0] cnt_q;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic              dest_live;
    logic              advance;
    logic              hazard;

    main_decoder u_dec (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign rs        = instr[25:21];
    assign rt        = instr[20:16];
    assign dest_live = ZERO_REG_HAZARD ? 1'b1 : (ctrl_q.dest_reg != 5'd0);
    assign advance   = ~valid_q | out_ready;
    assign hazard    = valid_q & ctrl_q.mem_read & dest_live & in_valid &
                       ((rs == ctrl_q.dest_reg) | (uses_rt(instr[31:26]) & (rt == ctrl_q.dest_reg)));
    assign in_ready  = flush | (advance & ~hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else if (advance && hazard) begin
            // Bubble: the dependent instruction waits upstream one cycle.
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            if (cnt_q != '1) cnt_q <= cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end else if (advance && in_valid) begin
            valid_q   <= 1'b1;
            ctrl_q    <= dec_ctrl;
            illegal_q <= dec_illegal;
        end else if (advance) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign Alu_op     = ctrl_q.alu_op;
    assign Alu_src    = ctrl_q.alu_src;
    assign Ext_op     = ctrl_q.ext_op;
    assign Reg_write  = ctrl_q.reg_write;
    assign Reg_dst    = ctrl_q.reg_dst;
    assign Mem_read   = ctrl_q.mem_read;
    assign Mem_write  = ctrl_q.mem_write;
    assign Branch     = ctrl_q.branch;
    assign Jump       = ctrl_q.jump;
    assign Dest_reg   = ctrl_q.dest_reg;
    assign Illegal    = illegal_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Randomized and directed bench for id_ex_ctrl_stage against an instruction-level model.
module tb_id_ex_ctrl_stage;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   instr = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          flush = 1'b0;
    logic          in_ready, out_valid, Alu_src, Ext_op, Reg_write, Mem_read, Mem_write, Illegal;
    logic [3:0]    Alu_op;
    logic [1:0]    Reg_dst, Branch, Jump;
    logic [4:0]    Dest_reg;
    logic [PW-1:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_ctrl_stage #(.PERF_W(PW), .ZERO_REG_HAZARD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid), .flush(flush), .Alu_op(Alu_op),
        .Alu_src(Alu_src), .Ext_op(Ext_op), .Reg_write(Reg_write), .Reg_dst(Reg_dst),
        .Mem_read(Mem_read), .Mem_write(Mem_write), .Branch(Branch), .Jump(Jump),
        .Dest_reg(Dest_reg), .Illegal(Illegal), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic       src, ext, rw;
        logic [1:0] dst;
        logic       mr, mwr;
        logic [1:0] br, jmp;
        logic [4:0] dest;
        logic       ill;
        logic       c_alu, c_src, c_ext;
    } exp_t;

    localparam logic [31:0] LW_8_9   = 32'h8D280000;  // lw   $8,0($9)
    localparam logic [31:0] LW_9_8   = 32'h8D090000;  // lw   $9,0($8)
    localparam logic [31:0] ADDU_DEP = 32'h01035021;  // addu $10,$8,$3
    localparam logic [31:0] ADDU_2   = 32'h00851021;  // addu $2,$4,$5
    localparam logic [31:0] ORI_FFFF = 32'h3401FFFF;  // ori  $1,$0,0xFFFF
    localparam logic [31:0] BEQ_0    = 32'h10000000;  // beq  $0,$0,0

    int   checks = 0;
    int   errors = 0;
    bit   mvalid = 1'b0;
    exp_t mword = '0;
    int   mcnt = 0;

    // Expected control word derived from the instruction set table.
    function automatic exp_t model_dec(input logic [31:0] i);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        e = '0;
        e.c_alu = 1'b1; e.c_src = 1'b1; e.c_ext = 1'b1;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'h00) begin
            e.rw = 1'b1; e.dst = 2'd1; e.dest = i[15:11]; e.c_ext = 1'b0;
            case (fn)
                6'h21: e.alu = 4'h0;
                6'h23: e.alu = 4'h1;
                6'h24: e.alu = 4'h2;
                6'h25: e.alu = 4'h3;
                6'h26: e.alu = 4'h4;
                6'h27: e.alu = 4'h5;
                6'h2A: e.alu = 4'h6;
                6'h2B: e.alu = 4'h7;
                6'h00: e.alu = 4'h8;
                6'h02: e.alu = 4'h9;
                6'h03: e.alu = 4'hA;
                6'h08: begin e.rw = 1'b0; e.jmp = 2'd2; e.c_alu = 1'b0; e.c_src = 1'b0; end
                default: e.ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h09: begin e.alu = 4'h0; e.src = 1; e.ext = 1; e.rw = 1; e.dest = i[20:16]; end
                6'h0A: begin e.alu = 4'h6; e.src = 1; e.ext = 1; e.rw = 1; e.dest = i[20:16]; end
                6'h0B: begin e.alu = 4'h7; e.src = 1; e.ext = 1; e.rw = 1; e.dest = i[20:16]; end
                6'h0C: begin e.alu = 4'h2; e.src = 1; e.ext = 0; e.rw = 1; e.dest = i[20:16]; end
                6'h0D: begin e.alu = 4'h3; e.src = 1; e.ext = 0; e.rw = 1; e.dest = i[20:16]; end
                6'h0E: begin e.alu = 4'h4; e.src = 1; e.ext = 0; e.rw = 1; e.dest = i[20:16]; end
                6'h0F: begin e.alu = 4'hB; e.src = 1; e.c_ext = 0; e.rw = 1; e.dest = i[20:16]; end
                6'h23: begin e.alu = 4'h0; e.src = 1; e.ext = 1; e.rw = 1; e.mr = 1; e.dest = i[20:16]; end
                6'h2B: begin e.alu = 4'h0; e.src = 1; e.ext = 1; e.mwr = 1; end
                6'h04: begin e.alu = 4'h1; e.c_ext = 0; e.br = 2'd1; end
                6'h05: begin e.alu = 4'h1; e.c_ext = 0; e.br = 2'd2; end
                6'h02: begin e.jmp = 2'd1; e.c_alu = 0; e.c_src = 0; e.c_ext = 0; end
                6'h03: begin e.jmp = 2'd1; e.rw = 1; e.dst = 2'd2; e.dest = 5'd31;
                             e.c_alu = 0; e.c_src = 0; e.c_ext = 0; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic bit model_hazard();
        logic [5:0] op;
        bit reads_rt;
        op = instr[31:26];
        reads_rt = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        return mvalid && mword.mr && (mword.dest != 5'd0) && in_valid &&
               ((instr[25:21] == mword.dest) || (reads_rt && (instr[20:16] == mword.dest)));
    endfunction

    function automatic bit model_ready();
        return flush || ((!mvalid || out_ready) && !model_hazard());
    endfunction

    function automatic logic [25:0] obs_vec();
        return {out_valid, Alu_op, Alu_src, Ext_op, Reg_write, Reg_dst, Mem_read, Mem_write,
                Branch, Jump, Dest_reg, Illegal, bubble_cnt};
    endfunction

    function automatic logic [25:0] exp_vec();
        logic [PW-1:0] c;
        c = PW'(mcnt);
        return {mvalid, mword.alu, mword.src, mword.ext, mword.rw, mword.dst, mword.mr, mword.mwr,
                mword.br, mword.jmp, mword.dest, mword.ill, c};
    endfunction

    function automatic logic [25:0] care_vec();
        logic [25:0] m;
        m = '1;
        if (mvalid) begin
            if (!mword.c_alu) m[24:21] = '0;
            if (!mword.c_src) m[20] = 1'b0;
            if (!mword.c_ext) m[19] = 1'b0;
            if (!mword.rw) begin m[17:16] = '0; m[9:5] = '0; end
        end
        return m;
    endfunction

    task automatic drive(input bit v, input logic [31:0] i, input bit ordy, input bit fl);
        in_valid = v; instr = i; out_ready = ordy; flush = fl;
        #1;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic step();
        bit   adv = !mvalid || out_ready;
        bit   hz = model_hazard();
        bit   nv = mvalid;
        exp_t nw = mword;
        int   nc = mcnt;
        if (flush) begin
            nv = 1'b0; nw = '0;
        end else if (adv && hz) begin
            nv = 1'b0; nw = '0;
            if (nc < (1 << PW) - 1) nc++;
        end else if (adv && in_valid) begin
            nv = 1'b1; nw = model_dec(instr);
        end else if (adv) begin
            nv = 1'b0; nw = '0;
        end
        @(posedge clk);
        #1;
        mvalid = nv; mword = nw; mcnt = nc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mvalid = 1'b0; mword = '0; mcnt = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== 26'h0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), 26'h0);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_addu();
        drive(1'b1, ADDU_2, 1'b1, 1'b0);
        step();
        checks++;
        if ({out_valid, Alu_op, Reg_write, Reg_dst, Dest_reg} !== {1'b1, 4'h0, 1'b1, 2'd1, 5'd2}) begin
            errors++; $display("FAIL addu_fields: got %h expected %h",
                {out_valid, Alu_op, Reg_write, Reg_dst, Dest_reg}, {1'b1, 4'h0, 1'b1, 2'd1, 5'd2});
        end
        checks++;
        if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
            errors++; $display("FAIL addu_word: got %h expected %h", obs_vec() & care_vec(), exp_vec() & care_vec());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, LW_8_9, 1'b1, 1'b0);
        step();
        checks++;
        if ({out_valid, Mem_read, Dest_reg} !== {1'b1, 1'b1, 5'd8}) begin
            errors++; $display("FAIL lu_load: got %h expected %h", {out_valid, Mem_read, Dest_reg}, {1'b1, 1'b1, 5'd8});
        end
        drive(1'b1, ADDU_DEP, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL lu_stall_ready: got %b expected 0", in_ready);
        end
        step();
        checks++;
        if ({out_valid, bubble_cnt} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL lu_bubble: got %h expected %h", {out_valid, bubble_cnt}, {1'b0, 4'd1});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL lu_resume_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if ({out_valid, Alu_op, Dest_reg, bubble_cnt} !== {1'b1, 4'h0, 5'd10, 4'd1}) begin
            errors++; $display("FAIL lu_dependent: got %h expected %h",
                {out_valid, Alu_op, Dest_reg, bubble_cnt}, {1'b1, 4'h0, 5'd10, 4'd1});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, LW_8_9, 1'b1, 1'b0);
        step();
        drive(1'b1, LW_9_8, 1'b1, 1'b0);
        step();
        checks++;
        if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec()) || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_bubble: got %h expected %h", obs_vec() & care_vec(), exp_vec() & care_vec());
        end
        step();
        checks++;
        if ({out_valid, Mem_read, Dest_reg} !== {1'b1, 1'b1, 5'd9}) begin
            errors++; $display("FAIL b2b_second_load: got %h expected %h", {out_valid, Mem_read, Dest_reg}, {1'b1, 1'b1, 5'd9});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_stall();
        drive(1'b1, ORI_FFFF, 1'b1, 1'b0);
        step();
        drive(1'b1, ADDU_2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready_%0d: got %b expected 0", k, in_ready);
            end
            step();
            checks++;
            if ({out_valid, Alu_op, Ext_op, Alu_src, Dest_reg} !== {1'b1, 4'h3, 1'b0, 1'b1, 5'd1}) begin
                errors++; $display("FAIL stall_hold_%0d: got %h expected %h", k,
                    {out_valid, Alu_op, Ext_op, Alu_src, Dest_reg}, {1'b1, 4'h3, 1'b0, 1'b1, 5'd1});
            end
        end
        drive(1'b1, ADDU_2, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
            errors++; $display("FAIL stall_release_word: got %h expected %h", obs_vec() & care_vec(), exp_vec() & care_vec());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_flush();
        drive(1'b1, BEQ_0, 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %b expected 1", in_ready);
        end
        step();
        checks++;
        if ({out_valid, Branch} !== {1'b0, 2'd0}) begin
            errors++; $display("FAIL flush_kill: got %h expected %h", {out_valid, Branch}, {1'b0, 2'd0});
        end
        drive(1'b1, BEQ_0, 1'b1, 1'b0);
        step();
        checks++;
        if ({out_valid, Branch, Alu_op, Reg_write} !== {1'b1, 2'd1, 4'h1, 1'b0}) begin
            errors++; $display("FAIL beq_word: got %h expected %h", {out_valid, Branch, Alu_op, Reg_write}, {1'b1, 2'd1, 4'h1, 1'b0});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'hFC000000, 1'b1, 1'b0);
        step();
        checks++;
        if ({out_valid, Illegal, Reg_write, Mem_write, Mem_read} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL illegal_op: got %h expected %h",
                {out_valid, Illegal, Reg_write, Mem_write, Mem_read}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        drive(1'b1, 32'h0000003F, 1'b1, 1'b0);
        step();
        checks++;
        if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec()) || Illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_funct: got %h expected %h", obs_vec() & care_vec(), exp_vec() & care_vec());
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, LW_8_9, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        mvalid = 1'b0; mword = '0; mcnt = 0;
        #1;
        checks++;
        if (obs_vec() !== 26'h0) begin
            errors++; $display("FAIL reset_mid_stall: got %h expected %h", obs_vec(), 26'h0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < (1 << PW) + 4; k++) begin
            drive(1'b1, LW_8_9, 1'b1, 1'b0);
            step();
            drive(1'b1, ADDU_DEP, 1'b1, 1'b0);
            step();
            checks++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                errors++; $display("FAIL sat_bubble_%0d: got %h expected %h", k, obs_vec() & care_vec(), exp_vec() & care_vec());
            end
            step();
        end
        checks++;
        if (bubble_cnt !== {PW{1'b1}}) begin
            errors++; $display("FAIL sat_count: got %h expected %h", bubble_cnt, {PW{1'b1}});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [12];
        logic [5:0] iops [7];
        logic [5:0] bops [3];
        logic [4:0] rs, rt, rd;
        fns  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
        iops = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        bops = '{6'h2B, 6'h04, 6'h05};
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0:       return {6'h23, rs, rt, 16'($urandom)};
            1:       return {6'h00, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 11)]};
            2:       return {iops[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
            3:       return {bops[$urandom_range(0, 2)], rs, rt, 16'($urandom)};
            4:       return {6'($urandom_range(2, 3)), rs, rt, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] cur;
        bit          v;
        bit          held;
        do_reset();
        held = 1'b0;
        cur  = 32'h0;
        v    = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                cur = rand_instr();
                v   = ($urandom_range(0, 9) < 8);
            end
            drive(v, cur, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
            checks++;
            if (in_ready !== model_ready()) begin
                errors++; $display("FAIL rand_ready_%0d: got %b expected %b instr %h", n, in_ready, model_ready(), cur);
            end
            held = v && !model_ready();
            step();
            checks++;
            if ((obs_vec() & care_vec()) !== (exp_vec() & care_vec())) begin
                errors++; $display("FAIL rand_word_%0d: got %h expected %h", n, obs_vec() & care_vec(), exp_vec() & care_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_load_use();
        test_back_to_back();
        test_stall();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
